// File: rtl/ehgu_boxcar_avg_if.sv
// Handshake and delay-line bus of the boxcar averager.
interface ehgu_boxcar_avg_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOG2_WIN = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic                      sr_en;
  logic [WIDTH-1:0]          sr_data;
  logic [WIDTH-1:0]          dly_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [WIDTH+LOG2_WIN-1:0] out_sum;
  logic                      out_warm;

  // Upstream source, delay-line model and downstream sink side.
  modport master (
    output in_valid, in_data, dly_data, out_ready,
    input  in_ready, sr_en, sr_data, out_valid, out_data, out_sum, out_warm
  );

  // Averager side.
  modport slave (
    input  in_valid, in_data, dly_data, out_ready,
    output in_ready, sr_en, sr_data, out_valid, out_data, out_sum, out_warm
  );
endinterface

// File: rtl/ehgu_boxcar_avg.sv
// Running boxcar average over the last 2**LOG2_WIN accepted samples.
// Works with an external delay line (ehgu_sr_mem) that returns the sample
// accepted WINDOW samples earlier.
module ehgu_boxcar_avg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOG2_WIN = 4,
  parameter int unsigned ROUND    = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  ehgu_boxcar_avg_if.slave       bus
);

  localparam int unsigned WINDOW  = 1 << LOG2_WIN;
  localparam int unsigned SUM_W   = WIDTH + LOG2_WIN;
  localparam int unsigned FILL_W  = LOG2_WIN + 1;
  localparam int unsigned RND_W   = SUM_W + 1;
  localparam int unsigned RND_ADD = (ROUND != 0 && LOG2_WIN > 0) ? (1 << (LOG2_WIN - 1)) : 0;

  logic              s1_valid;
  logic [WIDTH-1:0]  s1_data;
  logic [SUM_W-1:0]  sum;
  logic [FILL_W-1:0] fill;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic              out_warm_q;

  logic              adv_c;
  logic              accept_c;
  logic              full_c;
  logic [SUM_W-1:0]  dly_term_c;
  logic [SUM_W-1:0]  sum_next_c;
  logic [FILL_W-1:0] fill_next_c;
  logic [RND_W-1:0]  rnd_c;
  logic [RND_W-1:0]  shr_c;
  logic [WIDTH-1:0]  avg_c;

  // Handshake, running-sum update and average for the result being loaded.
  always_comb begin
    adv_c       = bus.out_ready | ~out_valid_q;
    accept_c    = bus.in_valid & adv_c & ~clr;
    full_c      = (fill == FILL_W'(WINDOW));
    // Until the window is populated the delay line holds stale data.
    dly_term_c  = full_c ? SUM_W'(bus.dly_data) : '0;
    sum_next_c  = sum + SUM_W'(s1_data) - dly_term_c;
    fill_next_c = full_c ? fill : fill + FILL_W'(1);
    rnd_c       = RND_W'(sum_next_c) + RND_W'(RND_ADD);
    shr_c       = rnd_c >> LOG2_WIN;
    avg_c       = (|shr_c[RND_W-1:WIDTH]) ? '1 : shr_c[WIDTH-1:0];
  end

  assign bus.in_ready  = adv_c;
  assign bus.sr_en     = accept_c;
  assign bus.sr_data   = bus.in_data;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sum   = sum;
  assign bus.out_warm  = out_warm_q;

  // Stage 1: capture the accepted sample; holds while the output is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (adv_c) begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_data <= bus.in_data;
      end
    end
  end

  // Stage 2: accumulate, track fill level and load the result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum         <= '0;
      fill        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_warm_q  <= 1'b0;
    end else if (clr) begin
      sum         <= '0;
      fill        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_warm_q  <= 1'b0;
    end else if (adv_c) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        sum        <= sum_next_c;
        fill       <= fill_next_c;
        out_data_q <= avg_c;
        out_warm_q <= (fill_next_c == FILL_W'(WINDOW));
      end
    end
  end

endmodule

// File: tb/tb_ehgu_boxcar_avg.sv
// Directed bench for ehgu_boxcar_avg (window 4, truncating and rounding copies).
module tb_ehgu_boxcar_avg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned LOG2_WIN = 2;

  logic             clk;
  logic             rstn;
  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;
  logic [WIDTH-1:0] dly;
  logic [WIDTH-1:0] mem [4];

  int n_asrt = 0;
  int n_fail = 0;
  int stim[$];
  logic [31:0] q_d0[$];
  logic [31:0] q_s0[$];
  logic [31:0] q_w0[$];
  logic [31:0] q_d1[$];

  ehgu_boxcar_avg_if #(.WIDTH(WIDTH), .LOG2_WIN(LOG2_WIN)) if0 ();
  ehgu_boxcar_avg_if #(.WIDTH(WIDTH), .LOG2_WIN(LOG2_WIN)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if0.dly_data  = dly;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.out_ready = out_ready;
  assign if1.dly_data  = dly;

  ehgu_boxcar_avg #(.WIDTH(WIDTH), .LOG2_WIN(LOG2_WIN), .ROUND(0)) dut0 (
    .clk (clk), .rstn (rstn), .clr (clr), .bus (if0.slave)
  );
  ehgu_boxcar_avg #(.WIDTH(WIDTH), .LOG2_WIN(LOG2_WIN), .ROUND(1)) dut1 (
    .clk (clk), .rstn (rstn), .clr (clr), .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delay-line model: registered read of the sample 4 accepts back; contents stale after reset.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= 8'h5A;
    end else if (if0.sr_en) begin
      dly <= mem[3];
      for (int i = 3; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= if0.sr_data;
    end
  end

  // Collect every transferred result.
  always @(posedge clk) begin
    if (rstn && if0.out_valid && out_ready) begin
      q_d0.push_back(32'(if0.out_data));
      q_s0.push_back(32'(if0.out_sum));
      q_w0.push_back(32'(if0.out_warm));
      q_d1.push_back(32'(if1.out_data));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    q_d0.delete(); q_s0.delete(); q_w0.delete(); q_d1.delete();
  endtask

  function automatic logic [31:0] pop(inout logic [31:0] q[$]);
    if (q.size() == 0) return 32'hFFFF_FFFF;
    return q.pop_front();
  endfunction

  task automatic expect_res(input string tag, input int idx, input int d, input int s,
                            input int w, input int r);
    check($sformatf("%s[%0d].data", tag, idx), pop(q_d0), 32'(d));
    check($sformatf("%s[%0d].sum",  tag, idx), pop(q_s0), 32'(s));
    check($sformatf("%s[%0d].warm", tag, idx), pop(q_w0), 32'(w));
    check($sformatf("%s[%0d].rnd",  tag, idx), pop(q_d1), 32'(r));
  endtask

  task automatic send_stim();
    foreach (stim[i]) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(stim[i]);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    flush();
  endtask

  task automatic expect_t1(input string tag);
    check({tag, ".count"}, 32'(q_d0.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      int s;
      s = 100 * ((i < 3) ? i + 1 : 4);
      expect_res(tag, i, s / 4, s, (i >= 3) ? 1 : 0, s / 4);
    end
  endtask

  task automatic load_t1();
    stim.delete();
    repeat (6) stim.push_back(100);
  endtask

  initial begin
    int e2[9]  = '{0, 0, 0, 0, 50, 50, 50, 50, 0};
    int t3d[4] = '{63, 127, 191, 255};
    int t3r[4] = '{64, 128, 191, 255};
    int sent;

    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #3;
    check("rst.out_valid", 32'(if0.out_valid), 32'd0);
    check("rst.out_data",  32'(if0.out_data),  32'd0);
    check("rst.out_sum",   32'(if0.out_sum),   32'd0);
    check("rst.out_warm",  32'(if0.out_warm),  32'd0);
    check("rst.sr_en",     32'(if0.sr_en),     32'd0);
    #9 rstn = 1'b1;
    tick();
    check("rst.in_ready", 32'(if0.in_ready), 32'd1);

    // T1: constant 100 stream
    load_t1();
    send_stim();
    expect_t1("t1");

    // T2: single impulse leaves the window after 4 samples
    do_clr();
    stim = '{0, 0, 0, 0, 200, 0, 0, 0, 0};
    send_stim();
    check("t2.count", 32'(q_d0.size()), 32'd9);
    for (int i = 0; i < 9; i++) expect_res("t2", i, e2[i], e2[i] * 4, (i >= 3) ? 1 : 0, e2[i]);

    // T3: full-scale input
    do_clr();
    stim.delete();
    repeat (8) stim.push_back(255);
    send_stim();
    check("t3.count", 32'(q_d0.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      expect_res("t3", i, (i < 4) ? t3d[i] : 255, 255 * ((i < 4) ? i + 1 : 4),
                 (i >= 3) ? 1 : 0, (i < 4) ? t3r[i] : 255);

    // T4: 5-cycle downstream stall mid-stream
    do_clr();
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c < 8);
      in_valid  = (sent < 6);
      in_data   = 8'd100;
      if (c == 5) begin
        #1;
        check("t4.in_ready",  32'(if0.in_ready),  32'd0);
        check("t4.sr_en",     32'(if0.sr_en),     32'd0);
        check("t4.out_valid", 32'(if0.out_valid), 32'd1);
        check("t4.out_data",  32'(if0.out_data),  32'd50);
        check("t4.out_sum",   32'(if0.out_sum),   32'd200);
      end
      @(negedge clk);
      if (in_valid && if0.in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    check("t4.sent", 32'(sent), 32'd6);
    expect_t1("t4");

    // T5: clear after a full window of 100, then 4x 40
    do_clr();
    stim.delete();
    repeat (10) stim.push_back(100);
    send_stim();
    do_clr();
    stim = '{40, 40, 40, 40};
    send_stim();
    check("t5.count", 32'(q_d0.size()), 32'd4);
    for (int i = 0; i < 4; i++) expect_res("t5", i, 10 * (i + 1), 40 * (i + 1), (i == 3) ? 1 : 0, 10 * (i + 1));

    // Rounding: sums 2,3,3 truncate to 0 and round to 1
    do_clr();
    stim = '{2, 1, 0};
    send_stim();
    expect_res("rnd", 0, 0, 2, 0, 1);
    expect_res("rnd", 1, 0, 3, 0, 1);
    expect_res("rnd", 2, 0, 3, 0, 1);

    // T6: asynchronous reset mid-stream
    do_clr();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd100;
      tick();
    end
    check("t6.pre_valid", 32'(if0.out_valid), 32'd1);
    #1;
    rstn     = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t6.out_valid", 32'(if0.out_valid), 32'd0);
    check("t6.out_data",  32'(if0.out_data),  32'd0);
    check("t6.out_sum",   32'(if0.out_sum),   32'd0);
    check("t6.in_ready",  32'(if0.in_ready),  32'd1);
    @(posedge clk);
    #2 rstn = 1'b1;
    tick();
    flush();
    load_t1();
    send_stim();
    expect_t1("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
